// File: rtl/waveform_pkg.sv
// Shared types and constants for the waveform sequencer.
// Imported by the sequencer top and its prescaler.
package waveform_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_SAW    = 2'd0;
  localparam logic [1:0] SEL_SQUARE = 2'd1;
  localparam logic [1:0] SEL_MIX    = 2'd2;
  localparam logic [1:0] SEL_ZERO   = 2'd3;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/waveform_sequencer_prescaler.sv
// Sample-rate prescaler: ticks once every divider_i+1 clocks.
// The >= compare tolerates the divider shrinking mid-count.
module sample_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count_q;

  assign tick_o = enable_i && (count_q >= divider_i);

  // Count while enabled; restart on tick, hold at zero when disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/waveform_sequencer.sv
// Paces generator requests, gathers both results and emits
// one selected or mixed sample; flags overruns and timeouts.
module waveform_sequencer
  import waveform_pkg::*;
#(
  parameter int N_FRAC    = 7,
  parameter int DIV_WIDTH = 8,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  input  logic [1:0]           select_i,
  input  logic [N_FRAC:0]      cfg_phase_i,
  input  logic [N_FRAC:0]      cfg_amplitude_i,
  input  logic                 cfg_write_strobe_i,
  input  logic                 clear_flags_i,
  output logic [N_FRAC:0]      phase_o,
  output logic [N_FRAC:0]      amplitude_o,
  output logic                 next_data_strobe_o,
  input  logic [N_FRAC:0]      sawtooth_i,
  input  logic                 sawtooth_valid_strobe_i,
  input  logic [N_FRAC:0]      square_i,
  input  logic                 square_valid_strobe_i,
  output logic [N_FRAC:0]      sample_o,
  output logic                 sample_valid_strobe_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 timeout_o
);

  localparam int W = N_FRAC + 1;
  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

  state_t         state_q, state_d;
  logic           tick;
  logic           idle_tick;
  logic           timeout_evt;
  logic [W-1:0]   shadow_phase_q;
  logic [W-1:0]   shadow_amp_q;
  logic           pending_q;
  logic [W-1:0]   saw_q, sq_q;
  logic           saw_got_q, sq_got_q;
  logic           saw_done, sq_done;
  logic [3:0]     tcnt_q;
  logic [W:0]     sum;
  logic [W-1:0]   sel_val;
  logic [W-1:0]   sample_q;

  sample_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enable_i  (enable_i),
    .divider_i (divider_i),
    .tick_o    (tick)
  );

  assign idle_tick = tick && (state_q == IDLE);
  assign saw_done  = saw_got_q || sawtooth_valid_strobe_i;
  assign sq_done   = sq_got_q || square_valid_strobe_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and timeout detection.
  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    unique case (state_q)
      IDLE: if (tick) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (saw_done && sq_done) begin
          state_d = OUT;
        end else if (tcnt_q == TO_CNT) begin
          state_d     = IDLE;
          timeout_evt = 1'b1;
        end
      end
      OUT:  state_d = IDLE;
    endcase
  end

  assign next_data_strobe_o    = (state_q == REQ);
  assign sample_valid_strobe_o = (state_q == OUT);
  assign busy_o                = (state_q != IDLE);

  // Shadow config and its transfer into the active registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_phase_q <= '0;
      shadow_amp_q   <= '0;
      pending_q      <= 1'b0;
      phase_o        <= '0;
      amplitude_o    <= '0;
    end else begin
      if (cfg_write_strobe_i) begin
        shadow_phase_q <= cfg_phase_i;
        shadow_amp_q   <= cfg_amplitude_i;
      end
      if (idle_tick && pending_q) begin
        phase_o     <= shadow_phase_q;
        amplitude_o <= shadow_amp_q;
      end
      if (cfg_write_strobe_i) pending_q <= 1'b1;
      else if (idle_tick)     pending_q <= 1'b0;
    end
  end

  // Capture generator results and age the wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      saw_q     <= '0;
      sq_q      <= '0;
      saw_got_q <= 1'b0;
      sq_got_q  <= 1'b0;
      tcnt_q    <= '0;
    end else if (state_q == REQ) begin
      saw_got_q <= 1'b0;
      sq_got_q  <= 1'b0;
      tcnt_q    <= '0;
    end else if (state_q == WAIT) begin
      if (sawtooth_valid_strobe_i) begin
        saw_q     <= sawtooth_i;
        saw_got_q <= 1'b1;
      end
      if (square_valid_strobe_i) begin
        sq_q     <= square_i;
        sq_got_q <= 1'b1;
      end
      tcnt_q <= tcnt_q + 4'd1;
    end
  end

  // Output select; mix is a sign-extended add then halve.
  always_comb begin
    sum     = {saw_q[W-1], saw_q} + {sq_q[W-1], sq_q};
    sel_val = '0;
    unique case (select_i)
      SEL_SAW:    sel_val = saw_q;
      SEL_SQUARE: sel_val = sq_q;
      SEL_MIX:    sel_val = sum[W:1];
      SEL_ZERO:   sel_val = '0;
    endcase
  end

  assign sample_o = (state_q == OUT) ? sel_val : sample_q;

  // Hold the emitted sample until the next strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i)               sample_q <= '0;
    else if (state_q == OUT) sample_q <= sel_val;
  end

  // Sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (tick && state_q != IDLE) overrun_o <= 1'b1;
      else if (clear_flags_i)      overrun_o <= 1'b0;
      if (timeout_evt)             timeout_o <= 1'b1;
      else if (clear_flags_i)      timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_waveform_sequencer.sv
// Directed bench for waveform_sequencer.
// The bench plays the generator and checks timing and data.
module tb_waveform_sequencer;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [7:0] divider_i;
  logic [1:0] select_i;
  logic [7:0] cfg_phase_i;
  logic [7:0] cfg_amplitude_i;
  logic       cfg_write_strobe_i;
  logic       clear_flags_i;
  logic [7:0] phase_o;
  logic [7:0] amplitude_o;
  logic       next_data_strobe_o;
  logic [7:0] sawtooth_i;
  logic       sawtooth_valid_strobe_i;
  logic [7:0] square_i;
  logic       square_valid_strobe_i;
  logic [7:0] sample_o;
  logic       sample_valid_strobe_o;
  logic       busy_o;
  logic       overrun_o;
  logic       timeout_o;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int r0     = 0;

  always #5 clk = ~clk;

  waveform_sequencer dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .enable_i                (enable_i),
    .divider_i               (divider_i),
    .select_i                (select_i),
    .cfg_phase_i             (cfg_phase_i),
    .cfg_amplitude_i         (cfg_amplitude_i),
    .cfg_write_strobe_i      (cfg_write_strobe_i),
    .clear_flags_i           (clear_flags_i),
    .phase_o                 (phase_o),
    .amplitude_o             (amplitude_o),
    .next_data_strobe_o      (next_data_strobe_o),
    .sawtooth_i              (sawtooth_i),
    .sawtooth_valid_strobe_i (sawtooth_valid_strobe_i),
    .square_i                (square_i),
    .square_valid_strobe_i   (square_valid_strobe_i),
    .sample_o                (sample_o),
    .sample_valid_strobe_o   (sample_valid_strobe_o),
    .busy_o                  (busy_o),
    .overrun_o               (overrun_o),
    .timeout_o               (timeout_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (next_data_strobe_o) break;
    end
    chk("req_seen", 32'(next_data_strobe_o), 32'd1);
  endtask

  // Called in the REQ cycle; valids arrive ds/dq cycles later.
  task automatic respond(input int ds, input int dq,
                         input logic [7:0] sv, input logic [7:0] qv,
                         input logic [7:0] exp, input int cw_k);
    int last;
    last = (ds > dq) ? ds : dq;
    for (int k = 1; k <= last; k++) begin
      step();
      sawtooth_valid_strobe_i = (k == ds);
      square_valid_strobe_i   = (k == dq);
      sawtooth_i = (k == ds) ? sv : ~sv;
      square_i   = (k == dq) ? qv : ~qv;
      cfg_write_strobe_i = (k == cw_k);
      chk("no_early_sample", 32'(sample_valid_strobe_o), 32'd0);
    end
    step();
    sawtooth_valid_strobe_i = 1'b0;
    square_valid_strobe_i   = 1'b0;
    cfg_write_strobe_i      = 1'b0;
    chk("sample_strobe", 32'(sample_valid_strobe_o), 32'd1);
    chk("sample_value", 32'(sample_o), 32'(exp));
  endtask

  initial begin
    rst_i = 1'b1;
    enable_i = 1'b0;
    divider_i = 8'd9;
    select_i = 2'd0;
    cfg_phase_i = 8'h00;
    cfg_amplitude_i = 8'h00;
    cfg_write_strobe_i = 1'b0;
    clear_flags_i = 1'b0;
    sawtooth_i = 8'h00;
    sawtooth_valid_strobe_i = 1'b0;
    square_i = 8'h00;
    square_valid_strobe_i = 1'b0;

    repeat (3) step();
    chk("reset_outputs",
        32'({phase_o, amplitude_o, sample_o, next_data_strobe_o,
             sample_valid_strobe_o, busy_o, overrun_o, timeout_o}),
        32'd0);

    rst_i = 1'b0;
    enable_i = 1'b1;
    wait_req(20);
    r0 = cyc;
    respond(2, 2, 8'h11, 8'h22, 8'h11, 0);
    chk("busy_in_out", 32'(busy_o), 32'd1);
    step();
    chk("sample_held", 32'(sample_o), 32'h11);
    chk("idle_not_busy", 32'(busy_o), 32'd0);
    select_i = 2'd1;
    cfg_phase_i = 8'h10;
    cfg_amplitude_i = 8'h40;

    wait_req(20);
    chk("req_period_10", 32'(cyc - r0), 32'd10);
    r0 = cyc;
    respond(2, 2, 8'h33, 8'h44, 8'h44, 1);
    chk("phase_not_yet", 32'({phase_o, amplitude_o}), 32'h0000);

    while (cyc < r0 + 9) step();
    cfg_phase_i = 8'h20;
    cfg_amplitude_i = 8'h50;
    cfg_write_strobe_i = 1'b1;
    step();
    cfg_write_strobe_i = 1'b0;
    chk("req_on_time", 32'(next_data_strobe_o), 32'd1);
    chk("cfg_applied", 32'({phase_o, amplitude_o}), 32'h1040);
    select_i = 2'd2;
    respond(2, 2, 8'h7F, 8'h80, 8'hFF, 0);
    step();

    wait_req(20);
    chk("cfg_late_apply", 32'({phase_o, amplitude_o}), 32'h2050);
    respond(2, 2, 8'h60, 8'h20, 8'h40, 0);
    step();
    wait_req(20);
    respond(2, 2, 8'h80, 8'h80, 8'h80, 0);
    step();
    select_i = 2'd3;
    wait_req(20);
    respond(2, 2, 8'h55, 8'h66, 8'h00, 0);
    step();
    select_i = 2'd0;
    wait_req(20);
    respond(5, 1, 8'h5A, 8'h3C, 8'h5A, 0);
    chk("no_flags", 32'({overrun_o, timeout_o}), 32'd0);
    step();

    divider_i = 8'd30;
    wait_req(40);
    r0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("no_sample_on_silence", 32'(sample_valid_strobe_o), 32'd0);
    end
    chk("still_waiting", 32'({busy_o, timeout_o}), 32'b10);
    step();
    chk("timeout_set", 32'({busy_o, timeout_o}), 32'b01);
    chk("no_sample_after_to", 32'(sample_valid_strobe_o), 32'd0);
    wait_req(40);
    chk("req_after_timeout", 32'(cyc - r0), 32'd31);
    respond(2, 2, 8'h21, 8'h43, 8'h21, 0);
    step();
    clear_flags_i = 1'b1;
    step();
    clear_flags_i = 1'b0;
    chk("flags_cleared", 32'({overrun_o, timeout_o}), 32'd0);

    divider_i = 8'd1;
    for (int i = 0; i < 10; i++) begin
      if (overrun_o) break;
      step();
    end
    chk("overrun_set", 32'(overrun_o), 32'd1);

    divider_i = 8'd9;
    wait_req(60);
    step();
    chk("wait_busy", 32'({busy_o, overrun_o}), 32'b11);
    chk("sample_before_rst", 32'(sample_o), 32'h21);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("reset_in_wait",
        32'({phase_o, amplitude_o, sample_o, next_data_strobe_o,
             sample_valid_strobe_o, busy_o, overrun_o, timeout_o}),
        32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/waveform_sequencer.md
Name: waveform_sequencer

Overview:
- Controller for the counter/sawtooth/square-pulse generator chain.
- Paces sample requests with a programmable prescaler and applies phase/amplitude updates only at sample boundaries (shadow → active).
- Collects both generator results and emits one selected or mixed sample with a valid strobe.
- Flags overruns and generator timeouts; sits between the register/control interface and the generator top.

Parameters:
- N_FRAC, 7, fractional bits; all data buses are N_FRAC+1 bits signed.
- DIV_WIDTH, 8, prescaler divider width.
- TIMEOUT, 15, max cycles in WAIT before abort (4-bit counter).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  run enable; low stops new requests
- divider_i  in  DIV_WIDTH  sample period minus one, in clocks
- select_i  in  2  0=sawtooth, 1=square, 2=mix (average), 3=zero
- cfg_phase_i  in  N_FRAC+1  signed phase increment (shadow)
- cfg_amplitude_i  in  N_FRAC+1  signed amplitude/threshold (shadow)
- cfg_write_strobe_i  in  1  load shadow config, set pending
- clear_flags_i  in  1  clear sticky flags
- phase_o  out  N_FRAC+1  active phase to generator
- amplitude_o  out  N_FRAC+1  active amplitude to generator
- next_data_strobe_o  out  1  one-cycle request to generator
- sawtooth_i  in  N_FRAC+1  generator sawtooth data
- sawtooth_valid_strobe_i  in  1
- square_i  in  N_FRAC+1  generator square data
- square_valid_strobe_i  in  1
- sample_o  out  N_FRAC+1  selected sample, held between strobes
- sample_valid_strobe_o  out  1  one-cycle sample valid
- busy_o  out  1  high in every state except IDLE
- overrun_o  out  1  sticky: tick dropped while busy
- timeout_o  out  1  sticky: generator did not answer in time

Behaviour:
- Reset values: all outputs 0; active/shadow regs 0; pending 0; prescaler 0; state IDLE.
- Prescaler:
  - While enable_i=1, counts up each cycle.
  - When count >= divider_i: tick=1 and count→0. The >= comparison absorbs a live decrease of divider_i.
  - While enable_i=0, count is held at 0 and no tick is produced.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - On tick: copy shadow→active if pending, clear pending, go to REQ.
  - The active registers change in the same cycle the state becomes REQ.
- REQ:
  - next_data_strobe_o=1 for exactly this cycle.
  - Clear the capture flags and the timeout counter; go to WAIT.
- WAIT:
  - Each valid strobe latches its data and sets its capture flag. Strobes may arrive in any order or in the same cycle.
  - When both flags are set (including the arrival cycle): go to OUT.
  - When the timeout counter reaches TIMEOUT: set timeout_o and go to IDLE with no sample strobe.
- OUT:
  - Register sample_o from select_i as sampled in this cycle; sample_valid_strobe_o=1 for one cycle; go to IDLE.
  - Mix mode: sample_o = (sawtooth + square) >>> 1, computed at N_FRAC+2 bits, arithmetic shift, no overflow possible.
  - Zero mode: sample_o = 0.
- Latency: tick in cycle T → next_data_strobe_o in T+1. Both valids received in cycle V → sample_valid_strobe_o in V+1.
- Tick while state ≠ IDLE: the tick is dropped and overrun_o is set. divider_i=0 therefore always overruns (minimum transaction is 4 cycles).
- Config write:
  - Always loads the shadow registers and sets pending.
  - A write in the same cycle as an IDLE tick is not applied to that request; it is applied at the next request.
- enable_i falling mid-transaction: the transaction completes normally.
- Strobes arriving outside WAIT are ignored.
- Sticky flags:
  - clear_flags_i clears overrun_o and timeout_o.
  - A set event in the same cycle as a clear wins (flag stays 1).
- rst_i asserted in any state returns all state to reset values in the next cycle.

Decomposition:
- Package waveform_pkg holds:
  - state encoding (IDLE=0, REQ=1, WAIT=2, OUT=3);
  - select codes SEL_SAW=0, SEL_SQUARE=1, SEL_MIX=2, SEL_ZERO=3;
  - TIMEOUT default.
- One natural sub-module: sample_prescaler (counter, >= compare, enable hold, tick output).

Test Plan:
- Divider=9, enable, generator model answers both valids 2 cycles after request → next_data_strobe_o every 10 cycles, sample_valid_strobe_o 3 cycles after each request, no flags set.
- cfg write phase=0x10, amplitude=0x40 during WAIT → phase_o/amplitude_o unchanged until the next IDLE tick, then 0x10/0x40. A write coincident with the tick applies one request later.
- select=2, sawtooth=0x7F, square=0x80 → sample_o=0xFF (-1). sawtooth=0x60, square=0x20 → sample_o=0x40.
- Square valid 1 cycle, sawtooth valid 5 cycles after request → single sample strobe the cycle after the sawtooth valid; data correct.
- Generator silent for 16 cycles → timeout_o=1, no sample strobe, return to IDLE, next tick issues a request. clear_flags_i → timeout_o=0.
- divider_i=1 → overrun_o=1 on the first dropped tick. rst_i asserted in WAIT → all outputs 0 next cycle, busy_o=0.
